// File: rtl/pipeline_debug_ctrl.sv
// Debug sequencer for the MIPS pipeline: run/step/stop gating, automatic halt on HALT_INST in ID,
// and a register-file dump streamed out over a valid/ready handshake.
module pipeline_debug_ctrl #(
   parameter int unsigned         INST_SZ   = 32,
   parameter int unsigned         REG_SZ    = 5,
   parameter int unsigned         REGS      = 32,
   parameter logic [INST_SZ-1:0]  HALT_INST = {INST_SZ{1'b1}}
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_cmd_valid,
   input  logic [1:0]         i_cmd,
   output logic               o_cmd_ready,
   input  logic [INST_SZ-1:0] i_instruction_D,
   output logic               o_pipe_en,
   output logic [REG_SZ-1:0]  o_dbg_reg_addr,
   input  logic [INST_SZ-1:0] i_dbg_reg_data,
   output logic [INST_SZ-1:0] o_data,
   output logic               o_data_valid,
   input  logic               i_data_ready,
   output logic [31:0]        o_cycle_count,
   output logic               o_halted,
   output logic [2:0]         o_state
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StRun    = 3'd1,
      StStep   = 3'd2,
      StHalted = 3'd3,
      StDumpRd = 3'd4,
      StDumpTx = 3'd5
   } state_e;

   localparam logic [1:0] CmdRun  = 2'b00;
   localparam logic [1:0] CmdStep = 2'b01;
   localparam logic [1:0] CmdDump = 2'b10;
   localparam logic [1:0] CmdStop = 2'b11;

   localparam logic [REG_SZ-1:0] LastIdx = REG_SZ'(REGS - 1);

   state_e               state_q, state_d;
   state_e               ret_q, ret_d;
   logic [REG_SZ-1:0]    idx_q, idx_d;
   logic [INST_SZ-1:0]   data_q, data_d;
   logic [31:0]          cycle_q, cycle_d;
   logic                 halted_q, halted_d;

   logic cmd_ready, pipe_en, data_valid;
   logic cmd_fire, halt_hit;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= StIdle;
         ret_q    <= StIdle;
         idx_q    <= '0;
         data_q   <= '0;
         cycle_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         cycle_q  <= cycle_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      cmd_fire = i_cmd_valid & cmd_ready;
      halt_hit = pipe_en & (i_instruction_D == HALT_INST);
      state_d  = state_q;
      ret_d    = ret_q;
      idx_d    = idx_q;
      data_d   = data_q;
      halted_d = halted_q;
      cycle_d  = pipe_en ? cycle_q + 32'd1 : cycle_q;
      case (state_q)
         StIdle: begin
            if (cmd_fire) begin
               case (i_cmd)
                  CmdRun:  state_d = StRun;
                  CmdStep: state_d = StStep;
                  CmdDump: begin
                     state_d = StDumpRd;
                     ret_d   = StIdle;
                  end
                  default: ;
               endcase
            end
         end
         // Halt outranks a simultaneous STOP and the STEP return to IDLE.
         StRun, StStep: begin
            if (halt_hit) begin
               state_d  = StHalted;
               halted_d = 1'b1;
            end else if (state_q == StStep) begin
               state_d = StIdle;
            end else if (cmd_fire && i_cmd == CmdStop) begin
               state_d = StIdle;
            end
         end
         StHalted: begin
            if (cmd_fire && i_cmd == CmdDump) begin
               state_d = StDumpRd;
               ret_d   = StHalted;
            end else if (cmd_fire && i_cmd == CmdStop) begin
               state_d  = StIdle;
               halted_d = 1'b0;
            end
         end
         StDumpRd: begin
            data_d  = i_dbg_reg_data;
            state_d = StDumpTx;
         end
         StDumpTx: begin
            if (i_data_ready) begin
               if (idx_q == LastIdx) begin
                  idx_d   = '0;
                  state_d = ret_q;
               end else begin
                  idx_d   = idx_q + REG_SZ'(1);
                  state_d = StDumpRd;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cmd_ready  = 1'b0;
      pipe_en    = 1'b0;
      data_valid = 1'b0;
      case (state_q)
         StIdle, StHalted: cmd_ready = 1'b1;
         StRun: begin
            cmd_ready = 1'b1;
            pipe_en   = 1'b1;
         end
         StStep:   pipe_en    = 1'b1;
         StDumpTx: data_valid = 1'b1;
         default: ;
      endcase
   end

   assign o_cmd_ready    = cmd_ready;
   assign o_pipe_en      = pipe_en;
   assign o_data_valid   = data_valid;
   assign o_dbg_reg_addr = idx_q;
   assign o_data         = data_q;
   assign o_cycle_count  = cycle_q;
   assign o_halted       = halted_q;
   assign o_state        = state_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Self-checking bench for pipeline_debug_ctrl: command sequencing, halt detection and
// scoreboarded register dumps against a register file that returns its own address.
module tb_pipeline_debug_ctrl;

   localparam logic [1:0]  CmdRun  = 2'b00;
   localparam logic [1:0]  CmdStep = 2'b01;
   localparam logic [1:0]  CmdDump = 2'b10;
   localparam logic [1:0]  CmdStop = 2'b11;
   localparam logic [31:0] Halt    = 32'hFFFF_FFFF;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_cmd_valid = 1'b0;
   logic [1:0]  i_cmd = 2'b00;
   logic        o_cmd_ready;
   logic [31:0] i_instruction_D = 32'h0;
   logic        o_pipe_en;
   logic [4:0]  o_dbg_reg_addr;
   logic [31:0] i_dbg_reg_data;
   logic [31:0] o_data;
   logic        o_data_valid;
   logic        i_data_ready = 1'b0;
   logic [31:0] o_cycle_count;
   logic        o_halted;
   logic [2:0]  o_state;

   int          errors = 0;
   int          checks = 0;
   int          beats  = 0;
   logic [31:0] sb_q[$];
   logic [31:0] base;
   logic        pv, rdy;
   logic [31:0] pd;

   pipeline_debug_ctrl dut (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_cmd_valid     (i_cmd_valid),
      .i_cmd           (i_cmd),
      .o_cmd_ready     (o_cmd_ready),
      .i_instruction_D (i_instruction_D),
      .o_pipe_en       (o_pipe_en),
      .o_dbg_reg_addr  (o_dbg_reg_addr),
      .i_dbg_reg_data  (i_dbg_reg_data),
      .o_data          (o_data),
      .o_data_valid    (o_data_valid),
      .i_data_ready    (i_data_ready),
      .o_cycle_count   (o_cycle_count),
      .o_halted        (o_halted),
      .o_state         (o_state)
   );

   // Register file model: each register holds its own index.
   assign i_dbg_reg_data = 32'(o_dbg_reg_addr);

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one edge; a beat that handshakes on that edge is compared with the scoreboard.
   task automatic tick();
      logic        fire;
      logic [31:0] d;
      fire = o_data_valid && i_data_ready;
      d    = o_data;
      @(posedge i_clk);
      #1;
      if (fire) begin
         beats++;
         if (sb_q.size() == 0) chk("dump_extra_beat", d, 32'hDEAD_BEEF);
         else                  chk("dump_beat", d, sb_q.pop_front());
      end
   endtask

   task automatic send_cmd(input logic [1:0] cmd);
      logic acc;
      acc         = 1'b0;
      i_cmd_valid = 1'b1;
      i_cmd       = cmd;
      for (int i = 0; i < 50 && !acc; i++) begin
         acc = o_cmd_ready;
         tick();
      end
      i_cmd_valid = 1'b0;
      chk("cmd_accepted", 32'(acc), 32'd1);
   endtask

   task automatic push_dump();
      for (int r = 0; r < 32; r++) sb_q.push_back(32'(r));
   endtask

   initial begin
      // Reset
      repeat (2) @(posedge i_clk);
      #1;
      i_reset = 1'b1;
      chk("rst_state", 32'(o_state), 32'd0);
      chk("rst_pipe_en", 32'(o_pipe_en), 32'd0);
      chk("rst_addr", 32'(o_dbg_reg_addr), 32'd0);
      chk("rst_data", o_data, 32'd0);
      chk("rst_valid", 32'(o_data_valid), 32'd0);
      chk("rst_count", o_cycle_count, 32'd0);
      chk("rst_halted", 32'(o_halted), 32'd0);
      chk("rst_ready", 32'(o_cmd_ready), 32'd1);

      // Single step
      send_cmd(CmdStep);
      chk("step_state", 32'(o_state), 32'd2);
      chk("step_pipe_en", 32'(o_pipe_en), 32'd1);
      tick();
      chk("step_done_state", 32'(o_state), 32'd0);
      chk("step_done_pipe_en", 32'(o_pipe_en), 32'd0);
      chk("step_count", o_cycle_count, 32'd1);
      for (int s = 0; s < 3; s++) begin
         send_cmd(CmdStep);
         tick();
      end
      chk("step4_count", o_cycle_count, 32'd4);

      // Run, then halt after 10 enabled cycles
      base = o_cycle_count;
      send_cmd(CmdRun);
      chk("run_pipe_en", 32'(o_pipe_en), 32'd1);
      repeat (10) tick();
      chk("run_still_en", 32'(o_pipe_en), 32'd1);
      i_instruction_D = Halt;
      tick();
      i_instruction_D = 32'h0;
      chk("halt_state", 32'(o_state), 32'd3);
      chk("halt_flag", 32'(o_halted), 32'd1);
      chk("halt_pipe_en", 32'(o_pipe_en), 32'd0);
      chk("halt_count", o_cycle_count, base + 32'd11);
      send_cmd(CmdRun);
      tick();
      chk("halted_run_state", 32'(o_state), 32'd3);
      chk("halted_run_count", o_cycle_count, base + 32'd11);

      // STOP out of HALTED, then STOP colliding with HALT
      send_cmd(CmdStop);
      chk("stop_state", 32'(o_state), 32'd0);
      chk("stop_clr_halted", 32'(o_halted), 32'd0);
      send_cmd(CmdRun);
      tick();
      i_cmd_valid     = 1'b1;
      i_cmd           = CmdStop;
      i_instruction_D = Halt;
      chk("collide_ready", 32'(o_cmd_ready), 32'd1);
      tick();
      i_cmd_valid     = 1'b0;
      i_instruction_D = 32'h0;
      chk("collide_state", 32'(o_state), 32'd3);
      chk("collide_halted", 32'(o_halted), 32'd1);

      // Dump from HALTED with ready toggling every cycle
      base  = o_cycle_count;
      beats = 0;
      push_dump();
      send_cmd(CmdDump);
      chk("dump_rd_state", 32'(o_state), 32'd4);
      for (int c = 0; c < 300 && (sb_q.size() != 0 || o_state != 3'd3); c++) begin
         pv           = o_data_valid;
         pd           = o_data;
         i_data_ready = ~i_data_ready;
         rdy          = i_data_ready;
         tick();
         if (pv && !rdy) chk("dump_hold", o_data, pd);
      end
      i_data_ready = 1'b0;
      chk("dump_beats", 32'(beats), 32'd32);
      chk("dump_sb_empty", 32'(sb_q.size()), 32'd0);
      chk("dump_ret_state", 32'(o_state), 32'd3);
      chk("dump_addr_wrap", 32'(o_dbg_reg_addr), 32'd0);
      chk("dump_count_frozen", o_cycle_count, base);

      // Reset in the middle of a dump
      push_dump();
      send_cmd(CmdDump);
      i_data_ready = 1'b1;
      for (int c = 0; c < 100 && !(o_state == 3'd5 && o_dbg_reg_addr == 5'd7); c++) tick();
      chk("reach_reg7", 32'(o_state == 3'd5 && o_dbg_reg_addr == 5'd7), 32'd1);
      i_reset = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(o_data_valid), 32'd0);
      chk("mid_rst_state", 32'(o_state), 32'd0);
      chk("mid_rst_addr", 32'(o_dbg_reg_addr), 32'd0);
      chk("mid_rst_count", o_cycle_count, 32'd0);
      chk("mid_rst_halted", 32'(o_halted), 32'd0);
      sb_q.delete();
      i_data_ready = 1'b0;
      tick();
      i_reset = 1'b1;
      beats   = 0;
      push_dump();
      send_cmd(CmdDump);
      i_data_ready = 1'b1;
      for (int c = 0; c < 150 && (sb_q.size() != 0 || o_state != 3'd0); c++) tick();
      i_data_ready = 1'b0;
      chk("redump_beats", 32'(beats), 32'd32);
      chk("redump_ret_state", 32'(o_state), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_debug_ctrl.md
# pipeline_debug_ctrl

Debug sequencer for the MIPS pipeline. It gates pipeline advance (run, single step, stop), halts automatically when the HALT instruction reaches the ID stage, and dumps the register file. The dump drives the register file's debug read address over all registers and streams each value out on a valid/ready handshake. It sits between the debug UART command decoder and the pipeline/ID stage; its `o_pipe_en` is the global enable of PC and all pipeline registers.

## Interface
Parameters:
- `INST_SZ`, 32, data/instruction width
- `REG_SZ`, 5, register address width
- `REGS`, 32, number of registers dumped
- `HALT_INST`, 32'hFFFF_FFFF, instruction encoding that halts the pipeline

Ports:
- `i_clk`  in  1  clock, rising edge
- `i_reset`  in  1  asynchronous, active-low reset
- `i_cmd_valid`  in  1  command strobe
- `i_cmd`  in  2  command: 00 RUN, 01 STEP, 10 DUMP, 11 STOP
- `o_cmd_ready`  out  1  command accepted when `i_cmd_valid & o_cmd_ready`
- `i_instruction_D`  in  INST_SZ  instruction currently in ID
- `o_pipe_en`  out  1  pipeline/PC advance enable
- `o_dbg_reg_addr`  out  REG_SZ  register file debug read address
- `i_dbg_reg_data`  in  INST_SZ  register file debug read data (combinational from address)
- `o_data`  out  INST_SZ  dumped register value
- `o_data_valid`  out  1  `o_data` valid
- `i_data_ready`  in  1  consumer ready
- `o_cycle_count`  out  32  number of cycles with `o_pipe_en`=1
- `o_halted`  out  1  HALT instruction seen
- `o_state`  out  3  current FSM state encoding

## Operation
- States and encodings: IDLE=0, RUN=1, STEP=2, HALTED=3, DUMP_RD=4, DUMP_TX=5.
- `o_cmd_ready`=1 in IDLE, RUN and HALTED; 0 in STEP, DUMP_RD and DUMP_TX. A sender holds its command until it is accepted.
- IDLE:
  - RUN goes to RUN.
  - STEP goes to STEP.
  - DUMP goes to DUMP_RD with return state IDLE.
  - STOP is consumed with no effect.
- RUN:
  - `o_pipe_en`=1.
  - STOP goes to IDLE.
  - RUN, STEP and DUMP are consumed with no effect.
- STEP: `o_pipe_en`=1 for exactly one cycle, then IDLE.
- Halt detection, in RUN or STEP: if `i_instruction_D`==HALT_INST on an edge where `o_pipe_en`=1, the next state is HALTED and `o_halted` is set.
  - Halt has priority over a simultaneous STOP and over the normal STEP→IDLE return.
- HALTED:
  - `o_pipe_en`=0.
  - DUMP goes to DUMP_RD with return state HALTED.
  - STOP goes to IDLE and clears `o_halted`.
  - RUN and STEP are consumed with no effect.
- DUMP_RD:
  - `o_dbg_reg_addr` holds the current index.
  - At the edge, `o_data` is loaded from `i_dbg_reg_data` and the state moves to DUMP_TX.
- DUMP_TX:
  - `o_data_valid`=1; `o_data` stays stable until the handshake.
  - On `i_data_ready`: if index==REGS-1, clear the index to 0 and return to the saved state; otherwise increment the index and go to DUMP_RD.
- `o_pipe_en`=0 in every DUMP state.
- `o_cycle_count` increments on every edge where `o_pipe_en`=1. It wraps from 0xFFFF_FFFF to 0 and is cleared only by reset.

## Timing
- Reset (async assert, sync release) values:
  - state IDLE
  - `o_pipe_en`=0
  - `o_dbg_reg_addr`=0
  - `o_data`=0
  - `o_data_valid`=0
  - `o_cycle_count`=0
  - `o_halted`=0
  - `o_cmd_ready`=1
- All outputs are registered or decoded from state only; there is no combinational path from input to output.
- Latency from command acceptance (edge N) to `o_pipe_en`=1 is cycle N+1.
- Latency from STOP acceptance to `o_pipe_en`=0 is the next cycle.
- Halt: HALT_INST is sampled at edge N with `o_pipe_en`=1. That edge still advances the pipeline; `o_pipe_en`=0 and `o_halted`=1 from cycle N+1.
- Dump throughput is 2 cycles per register minimum (DUMP_RD + DUMP_TX with ready high), so a full dump with no backpressure takes 64 cycles for REGS=32.
- Reset asserted mid-RUN or mid-DUMP forces all reset values immediately. A partially sent dump is abandoned.

## Test plan
- Reset: hold `i_reset`=0 for 2 cycles, then release → every output at its reset value and `o_state`=0.
- STEP with `i_instruction_D`=0: issue STEP → `o_pipe_en` high for exactly 1 cycle, `o_cycle_count`=1, then IDLE. Issue 3 more STEPs → `o_cycle_count`=4.
- RUN, then present HALT_INST after 10 enabled cycles → `o_halted`=1, `o_pipe_en`=0, `o_state`=3, `o_cycle_count`=11. A RUN command afterwards has no effect.
- STOP accepted in the same cycle that HALT_INST is sampled → HALTED, not IDLE.
- Register file model returns value = address. Issue DUMP from HALTED with `i_data_ready` toggling 1/0 every cycle → 32 beats with values 0..31 in order, `o_data` stable while not ready, `o_dbg_reg_addr` back to 0, return to HALTED.
- Assert `i_reset` low during DUMP_TX at register 7 → `o_data_valid`=0 and state IDLE within the same cycle. A new DUMP restarts from register 0.
